// File: rtl/alu_share_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_pkg
// Shared constants for the ALU-sharing controller: opcode encodings, FSM
// state encodings and a small one-hot helper used for per-requester strobes.
// Optional feature macro used by this slice: ALU_SHARE_FLAGS_EN.
// ---------------------------------------------------------------------------
package alu_share_ctrl_pkg;

  // ALU opcode encodings; 3'd7 is the single illegal code
  localparam logic [2:0] sOP_NULL    = 3'd0;
  localparam logic [2:0] sOP_ADD     = 3'd1;
  localparam logic [2:0] sOP_SUB     = 3'd2;
  localparam logic [2:0] sOP_AND     = 3'd3;
  localparam logic [2:0] sOP_OR      = 3'd4;
  localparam logic [2:0] sOP_XOR     = 3'd5;
  localparam logic [2:0] sOP_NOT     = 3'd6;
  localparam logic [2:0] sOP_ILLEGAL = 3'd7;

  // Controller FSM state encodings
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_EXEC = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Turn a requester index into its one-hot strobe position
  function automatic logic [1:0] idx_onehot(input logic idx);
    if (idx) begin
      idx_onehot = 2'b10;
    end else begin
      idx_onehot = 2'b01;
    end
  endfunction

endpackage

// File: rtl/alu_share_ctrl_if.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl_if
// Requester-side request/response bundle of the ALU-sharing controller.
//   req_valid/req_ready : per-requester request handshake (bit i = req i)
//   req_a/req_b/req_op  : packed operands/opcodes, requester 1 in upper slice
//   rsp_valid/rsp_ready : per-requester response handshake
//   rsp_data/rsp_err    : registered result and illegal-opcode indication
//   rsp_flags           : zero/carry flags, only with ALU_SHARE_FLAGS_EN
// master = requester side, slave = controller side.
// ---------------------------------------------------------------------------
interface alu_share_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3
);
  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [2*DATA_W-1:0] req_a;
  logic [2*DATA_W-1:0] req_b;
  logic [2*OP_W-1:0]   req_op;
  logic [1:0]          rsp_valid;
  logic [1:0]          rsp_ready;
  logic [DATA_W:0]     rsp_data;
  logic                rsp_err;
`ifdef ALU_SHARE_FLAGS_EN
  logic [1:0]          rsp_flags;
`endif

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_err
`ifdef ALU_SHARE_FLAGS_EN
    , input rsp_flags
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_err
`ifdef ALU_SHARE_FLAGS_EN
    , output rsp_flags
`endif
  );
endinterface

// File: rtl/alu_share_ctrl_rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin arbiter.
//   req[1:0] : request vector
//   ptr      : index that wins when both requests are present
//   gnt_vld  : at least one request present
//   gnt_idx  : index of the winner (0 when nothing is requested)
// ---------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic       gnt_vld,
  output logic       gnt_idx
);

  // A lone request always wins; a tie goes to the pointer
  always_comb begin
    gnt_vld = (req != 2'b00);
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ptr;
      default: gnt_idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// alu_share_ctrl
// Time-shares one external 8-bit ALU between two requesters. A round-robin
// winner is latched in IDLE, its operands drive the ALU during EXEC, and the
// registered 9-bit result is offered back in RESP until the winner takes it.
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   bus (slave)         : requester request/response bundle
//   alu_a/alu_b/alu_op  : latched operands/opcode to the ALU (registered)
//   alu_result          : combinational ALU result
//   busy                : FSM is not in IDLE
//   ops_done            : completed-response counter, wraps
// Optional feature: ALU_SHARE_FLAGS_EN adds bus.rsp_flags (zero, carry).
// ---------------------------------------------------------------------------
module alu_share_ctrl
  import alu_share_ctrl_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_share_ctrl_if.slave   bus,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W:0]   alu_result,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]        state_q,     state_d;
  logic              ptr_q,       ptr_d;
  logic              gnt_q,       gnt_d;
  logic [DATA_W-1:0] a_q,         a_d;
  logic [DATA_W-1:0] b_q,         b_d;
  logic [OP_W-1:0]   op_q,        op_d;
  logic [1:0]        req_ready_q, req_ready_d;
  logic [1:0]        rsp_valid_q, rsp_valid_d;
  logic [DATA_W:0]   rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              busy_q,      busy_d;
  logic [CNT_W-1:0]  ops_done_q,  ops_done_d;
`ifdef ALU_SHARE_FLAGS_EN
  logic [1:0]        flags_q,     flags_d;
`endif

  logic arb_vld;
  logic arb_idx;

  rr_arb2 u_arb (
    .req     (bus.req_valid),
    .ptr     (ptr_q),
    .gnt_vld (arb_vld),
    .gnt_idx (arb_idx)
  );

  // Next-state and datapath decisions for the IDLE -> EXEC -> RESP sequence
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    req_ready_d = 2'b00;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    ops_done_d  = ops_done_q;
`ifdef ALU_SHARE_FLAGS_EN
    flags_d     = flags_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (arb_vld) begin
          state_d     = ST_EXEC;
          gnt_d       = arb_idx;
          req_ready_d = idx_onehot(arb_idx);
          if (arb_idx) begin
            a_d  = bus.req_a[DATA_W +: DATA_W];
            b_d  = bus.req_b[DATA_W +: DATA_W];
            op_d = bus.req_op[OP_W +: OP_W];
          end else begin
            a_d  = bus.req_a[0 +: DATA_W];
            b_d  = bus.req_b[0 +: DATA_W];
            op_d = bus.req_op[0 +: OP_W];
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        rsp_valid_d = idx_onehot(gnt_q);
        if (op_q == sOP_ILLEGAL) begin
          // The ALU output is meaningless for the illegal code; return zero
          rsp_data_d = {(DATA_W+1){1'b0}};
          rsp_err_d  = 1'b1;
`ifdef ALU_SHARE_FLAGS_EN
          flags_d    = 2'b00;
`endif
        end else begin
          rsp_data_d = alu_result;
          rsp_err_d  = 1'b0;
`ifdef ALU_SHARE_FLAGS_EN
          flags_d    = {alu_result[DATA_W], (alu_result[DATA_W-1:0] == {DATA_W{1'b0}})};
`endif
        end
      end
      ST_RESP: begin
        // Only the granted requester's ready bit can complete the response
        if (bus.rsp_ready[gnt_q]) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 2'b00;
          ops_done_d  = ops_done_q + CNT_ONE;
          ptr_d       = ~gnt_q;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = 2'b00;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= 1'b0;
      gnt_q       <= 1'b0;
      a_q         <= {DATA_W{1'b0}};
      b_q         <= {DATA_W{1'b0}};
      op_q        <= {OP_W{1'b0}};
      req_ready_q <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= {(DATA_W+1){1'b0}};
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      ops_done_q  <= {CNT_W{1'b0}};
`ifdef ALU_SHARE_FLAGS_EN
      flags_q     <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      ops_done_q  <= ops_done_d;
`ifdef ALU_SHARE_FLAGS_EN
      flags_q     <= flags_d;
`endif
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
`ifdef ALU_SHARE_FLAGS_EN
  assign bus.rsp_flags = flags_q;
`endif
  assign alu_a    = a_q;
  assign alu_b    = b_q;
  assign alu_op   = op_q;
  assign busy     = busy_q;
  assign ops_done = ops_done_q;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_share_ctrl
// Bench for alu_share_ctrl: a stand-in ALU, a transaction-level model of the
// controller (one outstanding operation with an age count since acceptance),
// directed scenarios with literal expectations, then randomized traffic.
// ---------------------------------------------------------------------------
module tb_alu_share_ctrl;
  import alu_share_ctrl_pkg::*;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_op;
  logic [8:0]  alu_result;
  logic        busy;
  logic [15:0] ops_done;

  alu_share_ctrl_if bus ();

  alu_share_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .busy       (busy),
    .ops_done   (ops_done)
  );

  always #5 clk = ~clk;

  // Stand-in ALU; the illegal code produces junk the controller must mask
  function automatic logic [8:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    case (op)
      3'd1:    alu_fn = {1'b0, a} + {1'b0, b};
      3'd2:    alu_fn = {1'b0, a} - {1'b0, b};
      3'd3:    alu_fn = {1'b0, a & b};
      3'd4:    alu_fn = {1'b0, a | b};
      3'd5:    alu_fn = {1'b0, a ^ b};
      3'd6:    alu_fn = {1'b0, ~a};
      3'd7:    alu_fn = 9'h1A5;
      default: alu_fn = 9'h000;
    endcase
  endfunction

  assign alu_result = alu_fn(alu_a, alu_b, alu_op);

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Model: one operation in flight, aged in cycles since acceptance
  bit          m_busy;
  int          m_age;
  bit          m_gnt;
  bit          m_ptr;
  logic [7:0]  m_a;
  logic [7:0]  m_b;
  logic [2:0]  m_op;
  logic [8:0]  m_data;
  bit          m_err;
  logic [1:0]  m_flags;
  logic [15:0] m_count;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_gnt   = 1'b0;
    m_ptr   = 1'b0;
    m_a     = 8'h00;
    m_b     = 8'h00;
    m_op    = 3'd0;
    m_data  = 9'h000;
    m_err   = 1'b0;
    m_flags = 2'b00;
    m_count = 16'h0000;
  endtask

  // Advance the model by one rising edge using the inputs the DUT just sampled
  task automatic model_step();
    logic [8:0] r;
    if (!rst_n) begin
      model_reset();
    end else if (!m_busy) begin
      if (bus.req_valid != 2'b00) begin
        m_gnt   = (bus.req_valid == 2'b11) ? m_ptr : bus.req_valid[1];
        m_a     = m_gnt ? bus.req_a[15:8] : bus.req_a[7:0];
        m_b     = m_gnt ? bus.req_b[15:8] : bus.req_b[7:0];
        m_op    = m_gnt ? bus.req_op[5:3] : bus.req_op[2:0];
        r       = alu_fn(m_a, m_b, m_op);
        m_err   = (m_op == 3'd7);
        m_data  = m_err ? 9'h000 : r;
        m_flags = m_err ? 2'b00 : {r[8], (r[7:0] == 8'h00)};
        m_busy  = 1'b1;
        m_age   = 1;
      end
    end else if (m_age >= 2 && bus.rsp_ready[m_gnt]) begin
      m_busy  = 1'b0;
      m_count = m_count + 16'd1;
      m_ptr   = ~m_gnt;
    end else if (m_age < 2) begin
      m_age = m_age + 1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    cycle();
    cycle();
    rst_n = 1'b1;
  endtask

  // Compare every observable output against the model once per cycle
  always @(negedge clk) begin
    logic [1:0] oh;
    if (chk_en) begin
      oh = m_gnt ? 2'b10 : 2'b01;
      check("req_ready", bus.req_ready, (m_busy && m_age == 1) ? oh : 2'b00);
      check("rsp_valid", bus.rsp_valid, (m_busy && m_age >= 2) ? oh : 2'b00);
      check("busy", busy, m_busy);
      check("ops_done", ops_done, m_count);
      check("alu_a", alu_a, m_a);
      check("alu_b", alu_b, m_b);
      check("alu_op", alu_op, m_op);
      if ((m_busy && m_age >= 2) || !rst_n) begin
        check("rsp_data", bus.rsp_data, m_data);
        check("rsp_err", bus.rsp_err, m_err);
`ifdef ALU_SHARE_FLAGS_EN
        check("rsp_flags", bus.rsp_flags, m_flags);
`endif
      end
    end
  end

  initial begin
    bus.req_valid = 2'b00;
    bus.req_a     = 16'h0000;
    bus.req_b     = 16'h0000;
    bus.req_op    = 6'd0;
    bus.rsp_ready = 2'b00;
    model_reset();
    repeat (3) cycle();
    chk_en = 1'b1;
    check("reset_ops_done", ops_done, 16'h0000);
    check("reset_busy", busy, 1'b0);
    check("reset_rsp_valid", bus.rsp_valid, 2'b00);
    check("reset_req_ready", bus.req_ready, 2'b00);
    check("reset_rsp_data", bus.rsp_data, 9'h000);
    check("reset_alu_a", alu_a, 8'h00);
    rst_n = 1'b1;

    // Single ADD with carry out
    bus.req_valid = 2'b01;
    bus.req_a = 16'h00FF; bus.req_b = 16'h0001; bus.req_op = 6'o01;
    bus.rsp_ready = 2'b11;
    cycle();
    check("t1_req_ready", bus.req_ready, 2'b01);
    check("t1_busy", busy, 1'b1);
    bus.req_valid = 2'b00;
    cycle();
    check("t1_rsp_valid", bus.rsp_valid, 2'b01);
    check("t1_rsp_data", bus.rsp_data, 9'h100);
    check("t1_rsp_err", bus.rsp_err, 1'b0);
    cycle();
    check("t1_ops_done", ops_done, 16'h0001);

    // Simultaneous requests after reset: req0 first, then req1
    do_reset();
    bus.req_valid = 2'b11;
    bus.req_a = 16'hF005; bus.req_b = 16'h0F03; bus.req_op = 6'o52;
    bus.rsp_ready = 2'b11;
    cycle();
    check("t2_first_grant", bus.req_ready, 2'b01);
    cycle();
    check("t2_first_data", bus.rsp_data, 9'h002);
    cycle();
    check("t2_first_done", ops_done, 16'h0001);
    cycle();
    check("t2_second_grant", bus.req_ready, 2'b10);
    cycle();
    check("t2_second_valid", bus.rsp_valid, 2'b10);
    check("t2_second_data", bus.rsp_data, 9'h0FF);
    bus.req_valid = 2'b00;
    cycle();

    // Illegal opcode from requester 1
    bus.req_valid = 2'b10;
    bus.req_a = 16'h3C00; bus.req_b = 16'h5A00; bus.req_op = 6'o70;
    cycle();
    bus.req_valid = 2'b00;
    cycle();
    check("t3_rsp_valid", bus.rsp_valid, 2'b10);
    check("t3_rsp_data", bus.rsp_data, 9'h000);
    check("t3_rsp_err", bus.rsp_err, 1'b1);
    cycle();
    check("t3_ops_done", ops_done, 16'h0003);

    // Back-pressured AND; only the other requester's ready is high
    bus.req_valid = 2'b01;
    bus.req_a = 16'h00AA; bus.req_b = 16'h000F; bus.req_op = 6'o03;
    bus.rsp_ready = 2'b10;
    cycle();
    bus.req_valid = 2'b00;
    cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t4_hold_valid", bus.rsp_valid, 2'b01);
      check("t4_hold_data", bus.rsp_data, 9'h00A);
      check("t4_hold_busy", busy, 1'b1);
    end
    bus.rsp_ready = 2'b01;
    cycle();
    check("t4_release_valid", bus.rsp_valid, 2'b00);
    check("t4_ops_done", ops_done, 16'h0004);

    // Reset while the accepted operation is in EXEC
    bus.req_valid = 2'b01;
    bus.req_a = 16'h0001; bus.req_b = 16'h0002; bus.req_op = 6'o01;
    bus.rsp_ready = 2'b11;
    cycle();
    bus.req_valid = 2'b00;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("t5_busy", busy, 1'b0);
    check("t5_req_ready", bus.req_ready, 2'b00);
    check("t5_rsp_valid", bus.rsp_valid, 2'b00);
    check("t5_alu_a", alu_a, 8'h00);
    check("t5_ops_done", ops_done, 16'h0000);
    cycle();
    rst_n = 1'b1;
    repeat (4) cycle();
    check("t5_no_rsp", bus.rsp_valid, 2'b00);

    // SUB to zero
    bus.req_valid = 2'b01;
    bus.req_a = 16'h0007; bus.req_b = 16'h0007; bus.req_op = 6'o02;
    cycle();
    bus.req_valid = 2'b00;
    cycle();
    check("t6_rsp_data", bus.rsp_data, 9'h000);
`ifdef ALU_SHARE_FLAGS_EN
    check("t6_zero_flag", bus.rsp_flags, 2'b01);
`endif
    cycle();

    // Randomized traffic with occasional asynchronous resets
    for (int i = 0; i < 1500; i++) begin
      bus.req_valid = 2'($urandom_range(0, 3));
      bus.req_a     = 16'($urandom);
      bus.req_b     = 16'($urandom);
      bus.req_op    = 6'($urandom);
      bus.rsp_ready = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end else begin
        cycle();
      end
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
